// File: rtl/full_adder2_pkg.sv
// Shared constants and types for the full_adder2 ripple-carry adder.
package full_adder2_pkg;

  localparam int FA2_DEFAULT_WIDTH = 1;
  localparam int FA2_CNT_W         = 16;

  typedef logic [FA2_CNT_W-1:0] fa2_cnt_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic fa2_cnt_t fa2_sat_inc(input fa2_cnt_t v);
    fa2_cnt_t r;
    if (v == {FA2_CNT_W{1'b1}}) begin
      r = v;
    end else begin
      r = v + fa2_cnt_t'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/full_adder2_fa_bit_cell.sv
// Single-bit full-adder cell; chained by full_adder2 to form the ripple path.
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/full_adder2.sv
// WIDTH-bit ripple-carry adder with combinational and registered results.
// Optional status outputs (prop_all, carry_cnt) exist when FULL_ADDER2_STATUS_EN is defined.
module full_adder2
  import full_adder2_pkg::*;
#(
  parameter int WIDTH = FA2_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q
`ifdef FULL_ADDER2_STATUS_EN
  ,
  output logic                 prop_all,
  output logic [FA2_CNT_W-1:0] carry_cnt
`endif
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] sum_s;

  assign carry_s[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    fa_bit_cell u_cell (
      .a   (a[i]),
      .b   (b[i]),
      .cin (carry_s[i]),
      .s   (sum_s[i]),
      .cout(carry_s[i+1])
    );
  end

  assign sum       = sum_s;
  assign carry_out = carry_s[WIDTH];

  // One-cycle registered copy of the adder result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
    end else begin
      sum_q   <= sum_s;
      carry_q <= carry_s[WIDTH];
    end
  end

`ifdef FULL_ADDER2_STATUS_EN
  fa2_cnt_t carry_cnt_r;

  assign prop_all  = &(a ^ b);
  assign carry_cnt = carry_cnt_r;

  // Saturating count of clock edges that saw a carry out of the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_cnt_r <= {FA2_CNT_W{1'b0}};
    end else if (carry_s[WIDTH]) begin
      carry_cnt_r <= fa2_sat_inc(carry_cnt_r);
    end else begin
      carry_cnt_r <= carry_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_full_adder2.sv
// Directed, table-driven bench for full_adder2 at WIDTH=1 and WIDTH=8.
module tb_full_adder2;

  typedef struct {
    logic [2:0] abc;
    logic [1:0] exp;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec8_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0;
  logic       sum1, co1, sumq1, cq1;
  logic [7:0] a8 = 8'h00, b8 = 8'h00;
  logic       cin8 = 1'b0;
  logic [7:0] sum8, sumq8;
  logic       co8, cq8;
`ifdef FULL_ADDER2_STATUS_EN
  logic        pa1, pa8;
  logic [15:0] cnt1, cnt8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  full_adder2 #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .sum(sum1), .carry_out(co1), .sum_q(sumq1), .carry_q(cq1)
`ifdef FULL_ADDER2_STATUS_EN
    , .prop_all(pa1), .carry_cnt(cnt1)
`endif
  );

  full_adder2 #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .sum(sum8), .carry_out(co8), .sum_q(sumq8), .carry_q(cq8)
`ifdef FULL_ADDER2_STATUS_EN
    , .prop_all(pa8), .carry_cnt(cnt8)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec1_t tv1[8];
  vec8_t tv8[7];

  initial begin
    tv1[0] = '{3'b000, 2'b00};
    tv1[1] = '{3'b001, 2'b01};
    tv1[2] = '{3'b010, 2'b01};
    tv1[3] = '{3'b011, 2'b10};
    tv1[4] = '{3'b100, 2'b01};
    tv1[5] = '{3'b101, 2'b10};
    tv1[6] = '{3'b110, 2'b10};
    tv1[7] = '{3'b111, 2'b11};

    tv8[0] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    tv8[1] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tv8[2] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0};
    tv8[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv8[4] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    tv8[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tv8[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

    // Truth table while in reset: combinational path live, registers held at zero.
    #1;
    check("rst_sumq1", {63'd0, sumq1}, 64'd0);
    check("rst_cq1", {63'd0, cq1}, 64'd0);
    check("rst_sumq8", {56'd0, sumq8}, 64'd0);
    check("rst_cq8", {63'd0, cq8}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = tv1[i].abc;
      #5;
      check($sformatf("tt%0d", i), {62'd0, co1, sum1}, {62'd0, tv1[i].exp});
    end
    check("rst_hold_sumq1", {63'd0, sumq1}, 64'd0);
    check("rst_hold_cq1", {63'd0, cq1}, 64'd0);

    // Release reset and prime sum_q=1, carry_q=0.
    @(negedge clk);
    rst = 1'b0;
    {a1, b1, cin1} = 3'b001;
    @(posedge clk); #1;
    check("prime_sumq", {63'd0, sumq1}, 64'd1);
    check("prime_cq", {63'd0, cq1}, 64'd0);

    // One-cycle latency: old value held until the edge.
    @(negedge clk);
    {a1, b1, cin1} = 3'b110;
    #1;
    check("lat_comb", {62'd0, co1, sum1}, 64'd2);
    check("lat_hold_sumq", {63'd0, sumq1}, 64'd1);
    check("lat_hold_cq", {63'd0, cq1}, 64'd0);
    @(posedge clk); #1;
    check("lat_sumq", {63'd0, sumq1}, 64'd0);
    check("lat_cq", {63'd0, cq1}, 64'd1);

    // Async reset mid-cycle with sum_q=1.
    @(negedge clk);
    {a1, b1, cin1} = 3'b100;
    @(posedge clk); #1;
    check("ar_pre_sumq", {63'd0, sumq1}, 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_sumq", {63'd0, sumq1}, 64'd0);
    check("ar_cq", {63'd0, cq1}, 64'd0);
    check("ar_comb", {62'd0, co1, sum1}, 64'd1);
    {a1, b1, cin1} = 3'b111;
    #1;
    check("ar_comb2", {62'd0, co1, sum1}, 64'd3);
    @(posedge clk); #1;
    check("ar_held_sumq", {63'd0, sumq1}, 64'd0);
    check("ar_held_cq", {63'd0, cq1}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // WIDTH=8 vectors: combinational result, then registered copy one edge later.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      a8 = tv8[i].a; b8 = tv8[i].b; cin8 = tv8[i].cin;
      #1;
      check($sformatf("w8_sum%0d", i), {56'd0, sum8}, {56'd0, tv8[i].s});
      check($sformatf("w8_co%0d", i), {63'd0, co8}, {63'd0, tv8[i].co});
      @(posedge clk); #1;
      check($sformatf("w8_sumq%0d", i), {56'd0, sumq8}, {56'd0, tv8[i].s});
      check($sformatf("w8_cq%0d", i), {63'd0, cq8}, {63'd0, tv8[i].co});
    end

`ifdef FULL_ADDER2_STATUS_EN
    @(negedge clk);
    a8 = 8'h55; b8 = 8'hAA; cin8 = 1'b0;
    #1;
    check("prop_all_1", {63'd0, pa8}, 64'd1);
    a8 = 8'h55; b8 = 8'h55;
    #1;
    check("prop_all_0", {63'd0, pa8}, 64'd0);
    rst = 1'b1;
    #1;
    check("cnt_clr0", {48'd0, cnt8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("cnt_3", {48'd0, cnt8}, 64'd3);
    @(negedge clk);
    a8 = 8'h00; b8 = 8'h00;
    @(posedge clk); #1;
    check("cnt_hold", {48'd0, cnt8}, 64'd3);
    #2;
    rst = 1'b1;
    #1;
    check("cnt_clr", {48'd0, cnt8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
